hazard_fwd_unit: RTL and testbench



---
 rtl/hazard_fwd_unit.sv | 136 +++++++++++++
 tb/tb_hazard_fwd_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
// Hazard detection and operand-forwarding control for a 5-stage pipeline.
// Tracks the destination tags of the instructions in EX, MEM and WB and
// produces the EX operand-mux selects. A load in EX whose result is needed
// by the ID instruction stalls ID for one cycle and puts a bubble into EX.
//
// Optional feature: define HAZARD_STATS_EN to add the stall_count_o port
// (a saturating count of stall cycles).
//
// Ports:
//   clk_i           rising-edge clock
//   rst_n_i         synchronous reset, active low
//   id_valid_i      ID holds a real instruction
//   id_rs_i/id_rt_i ID source register indices
//   id_rd_i         ID destination register index
//   id_regwrite_i   ID instruction writes the register file
//   id_memread_i    ID instruction is a load
//   flush_i         squash the ID instruction
//   stall_o         hold PC and IF/ID this cycle
//   ex_valid_o      EX holds a real instruction
//   fwd_a_o/fwd_b_o EX operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   stall_count_o   stall-cycle counter (HAZARD_STATS_EN only)
module hazard_fwd_unit (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic [4:0]  id_rd_i,
  input  logic        id_regwrite_i,
  input  logic        id_memread_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        ex_valid_o,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stall_count_o,
`endif
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o
);

  typedef struct packed {
    logic       vld;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ex_tag_t;

  // Later stages only need to know who writes what.
  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       rw;
  } wr_tag_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  ex_tag_t ex_q, ex_d;
  wr_tag_t mem_q, wb_q;

  logic mem_wr, wb_wr, stall;

  // Writers to r0 never forward: r0 reads as zero from the register file.
  assign mem_wr = mem_q.vld & mem_q.rw & (mem_q.rd != 5'd0);
  assign wb_wr  = wb_q.vld  & wb_q.rw  & (wb_q.rd  != 5'd0);

  // Load-use: the load's data is not available until it leaves MEM, so the
  // dependent instruction waits one cycle and then takes the MEM/WB path.
  // A flushed ID instruction is dead, so it never stalls.
  always_comb begin
    stall = 1'b0;
    if (id_valid_i && !flush_i && ex_q.vld && ex_q.mr && ex_q.rw &&
        (ex_q.rd != 5'd0) && ((ex_q.rd == id_rs_i) || (ex_q.rd == id_rt_i)))
      stall = 1'b1;
  end

  assign stall_o    = stall;
  assign ex_valid_o = ex_q.vld;

  // MEM checked first: it holds the younger, more recent write.
  always_comb begin
    fwd_a_o = SEL_RF;
    fwd_b_o = SEL_RF;
    if (ex_q.vld) begin
      if (mem_wr && mem_q.rd == ex_q.rs)     fwd_a_o = SEL_MEM;
      else if (wb_wr && wb_q.rd == ex_q.rs)  fwd_a_o = SEL_WB;
      if (mem_wr && mem_q.rd == ex_q.rt)     fwd_b_o = SEL_MEM;
      else if (wb_wr && wb_q.rd == ex_q.rt)  fwd_b_o = SEL_WB;
    end
  end

  always_comb begin
    ex_d = '0;  // bubble
    if (id_valid_i && !stall && !flush_i) begin
      ex_d.vld = 1'b1;
      ex_d.rs  = id_rs_i;
      ex_d.rt  = id_rt_i;
      ex_d.rd  = id_rd_i;
      ex_d.rw  = id_regwrite_i;
      ex_d.mr  = id_memread_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= '{vld: ex_q.vld, rd: ex_q.rd, rw: ex_q.rw};
      wb_q  <= mem_q;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_count_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit. Inputs are driven just after the
// rising edge; outputs are sampled mid-cycle.
module tb_hazard_fwd_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_regwrite, id_memread, flush;
  logic        stall, ex_valid;
  logic [1:0]  fwd_a, fwd_b;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_regwrite),
    .id_memread_i  (id_memread),
    .flush_i       (flush),
    .stall_o       (stall),
    .ex_valid_o    (ex_valid),
`ifdef HAZARD_STATS_EN
    .stall_count_o (stall_count),
`endif
    .fwd_a_o       (fwd_a),
    .fwd_b_o       (fwd_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present an ID instruction (or idle when v=0) and let comb logic settle.
  task automatic id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                    input logic [4:0] rd, input logic rw, input logic mr,
                    input logic fl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    id_regwrite = rw; id_memread = mr; flush = fl;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
`ifdef HAZARD_STATS_EN
    chk(tag, stall_count, exp);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) tick();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_exv",   {31'd0, ex_valid}, 32'd0);
    chk("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("rst_fwd_b", {30'd0, fwd_b}, 32'd0);
    chk_cnt("rst_cnt", 32'd0);
    rst_n = 1'b1;

    // Back-to-back ALU: add r3 <- r1,r2 ; sub r6 <- r3,r4
    id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    chk("b2b_stall0", {31'd0, stall}, 32'd0);
    tick();
    id(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("b2b_stall1", {31'd0, stall}, 32'd0);
    tick();
    idle();
    chk("b2b_exv",   {31'd0, ex_valid}, 32'd1);
    chk("b2b_fwd_a", {30'd0, fwd_a}, 32'd2);
    chk("b2b_fwd_b", {30'd0, fwd_b}, 32'd0);
    drain();

    // Distance 2: add r5 ; nop ; or r7 <- r1,r5
    id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    id(1'b1, 5'd1, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    chk("d2_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("d2_fwd_b", {30'd0, fwd_b}, 32'd1);
    drain();

    // MEM priority: add r5 ; add r5 ; use r5,r5
    id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    id(1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    chk("pri_fwd_a", {30'd0, fwd_a}, 32'd2);
    chk("pri_fwd_b", {30'd0, fwd_b}, 32'd2);
    drain();

    // Load-use: lw r8 ; add r10 <- r8,r9
    id(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0);
    chk("lu_stall1", {31'd0, stall}, 32'd1);
    chk_cnt("lu_cnt0", 32'd0);
    tick();
    id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0);   // held in ID
    chk("lu_stall2", {31'd0, stall}, 32'd0);
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk_cnt("lu_cnt1", 32'd1);
    tick();
    idle();
    chk("lu_exv",   {31'd0, ex_valid}, 32'd1);
    chk("lu_fwd_a", {30'd0, fwd_a}, 32'd1);
    chk("lu_fwd_b", {30'd0, fwd_b}, 32'd0);
    chk_cnt("lu_cnt2", 32'd1);
    drain();

    // Register zero: add r0 ; read r0,r0
    id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    chk("r0_exv",   {31'd0, ex_valid}, 32'd1);
    chk("r0_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("r0_fwd_b", {30'd0, fwd_b}, 32'd0);
    drain();
    // lw r0 ; use r0 -> no stall
    id(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    id(1'b1, 5'd0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("r0_lu_stall", {31'd0, stall}, 32'd0);
    drain();

    // Flush over load-use
    id(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b1);
    chk("fl_stall", {31'd0, stall}, 32'd0);
    tick();
    idle();
    chk("fl_bubble", {31'd0, ex_valid}, 32'd0);
    chk_cnt("fl_cnt", 32'd1);
    drain();

    // Reset mid-stream with writers r11 and r12 in flight
    id(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    id(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_exv",   {31'd0, ex_valid}, 32'd0);
    chk("mr_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("mr_fwd_b", {30'd0, fwd_b}, 32'd0);
    chk_cnt("mr_cnt", 32'd0);
    id(1'b1, 5'd11, 5'd12, 5'd13, 1'b1, 1'b0, 1'b0);
    chk("mr_stall", {31'd0, stall}, 32'd0);
    tick();
    idle();
    chk("mr_rd_exv",   {31'd0, ex_valid}, 32'd1);
    chk("mr_rd_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("mr_rd_fwd_b", {30'd0, fwd_b}, 32'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
